// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-bit saturating direction counters
// Combinational lookup of the fetch PC; trained at the clock edge by resolved branches.
module branch_target_buffer #(
    parameter int ENTRY_NUM   = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = $clog2(ENTRY_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lookupPc,
    output logic                  btbHit,
    output logic [ADDR_WIDTH-1:0] btbPredictedPc,
    output logic                  isBranchTakenPredicted,
    input  logic                  updateEn,
    input  logic [ADDR_WIDTH-1:0] updatePc,
    input  logic [ADDR_WIDTH-1:0] updateTarget,
    input  logic                  updateTaken
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

    logic                  valid_q  [ENTRY_NUM];
    logic [TAG_WIDTH-1:0]  tag_q    [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0] target_q [ENTRY_NUM];
    logic [1:0]            ctr_q    [ENTRY_NUM];

    logic [INDEX_WIDTH-1:0] lk_idx;
    logic [TAG_WIDTH-1:0]   lk_tag;
    logic                   lk_hit;
    logic [INDEX_WIDTH-1:0] up_idx;
    logic [TAG_WIDTH-1:0]   up_tag;
    logic                   up_hit;
    logic [1:0]             up_ctr_d;
    logic                   unused_low_bits;

    // Instructions are word aligned, so the two low PC bits never select an entry.
    assign unused_low_bits = ^{lookupPc[1:0], updatePc[1:0]};

    assign lk_idx = lookupPc[INDEX_WIDTH+1:2];
    assign lk_tag = lookupPc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign btbHit                 = lk_hit;
    assign btbPredictedPc         = lk_hit ? target_q[lk_idx] : '0;
    assign isBranchTakenPredicted = lk_hit & ctr_q[lk_idx][1];

    assign up_idx = updatePc[INDEX_WIDTH+1:2];
    assign up_tag = updatePc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        up_ctr_d = ctr_q[up_idx];
        if (updateTaken && (ctr_q[up_idx] != 2'd3)) begin
            up_ctr_d = ctr_q[up_idx] + 2'd1;
        end else if (!updateTaken && (ctr_q[up_idx] != 2'd0)) begin
            up_ctr_d = ctr_q[up_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                valid_q[i]  <= 1'b0;
                ctr_q[i]    <= 2'd1;
                target_q[i] <= '0;
            end
        end else if (updateEn) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_d;
                if (updateTaken) begin
                    target_q[up_idx] <= updateTarget;
                end
            end else if (updateTaken) begin
                // Taken miss evicts whatever occupies the slot; not-taken misses never allocate.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= updateTarget;
                ctr_q[up_idx]    <= 2'd2;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer
// Directed scenarios plus random training against a behavioural BTB model.
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookupPc;
    logic        btbHit;
    logic [31:0] btbPredictedPc;
    logic        isBranchTakenPredicted;
    logic        updateEn;
    logic [31:0] updatePc;
    logic [31:0] updateTarget;
    logic        updateTaken;

    int checks = 0;
    int errors = 0;
    logic last_hit;

    bit          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned m_tgt   [64];
    int          m_ctr   [64];

    branch_target_buffer dut (
        .clk                    (clk),
        .rst                    (rst),
        .lookupPc               (lookupPc),
        .btbHit                 (btbHit),
        .btbPredictedPc         (btbPredictedPc),
        .isBranchTakenPredicted (isBranchTakenPredicted),
        .updateEn               (updateEn),
        .updatePc               (updatePc),
        .updateTarget           (updateTarget),
        .updateTaken            (updateTaken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic int idx_of(input int unsigned pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / 256;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
            m_tgt[i]   = 0;
        end
    endtask

    task automatic model_update(input int unsigned pc, input int unsigned tgt, input bit taken);
        int i;
        i = idx_of(pc);
        if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
            if (taken) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(pc);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
        end
    endtask

    // One cycle: drive inputs, compare the pre-edge lookup with the model, then advance the model.
    task automatic step(input bit r, input logic [31:0] lk, input bit en,
                        input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
        int  i;
        bit  e_hit;
        @(negedge clk);
        rst = r; lookupPc = lk; updateEn = en;
        updatePc = pc; updateTarget = tgt; updateTaken = taken;
        #1;
        i = idx_of(lk);
        e_hit = m_valid[i] && (m_tag[i] == tag_of(lk));
        last_hit = btbHit;
        check("hit", {31'd0, btbHit}, {31'd0, e_hit});
        check("target", btbPredictedPc, e_hit ? m_tgt[i] : 32'd0);
        check("taken", {31'd0, isBranchTakenPredicted}, {31'd0, e_hit && (m_ctr[i] >= 2)});
        @(posedge clk);
        if (r) model_reset();
        else if (en) model_update(pc, tgt, taken);
    endtask

    task automatic probe(input logic [31:0] lk, input bit e_hit, input logic [31:0] e_tgt, input bit e_tk);
        @(negedge clk);
        rst = 1'b0; lookupPc = lk; updateEn = 1'b0;
        #1;
        check("probe_hit", {31'd0, btbHit}, {31'd0, e_hit});
        check("probe_target", btbPredictedPc, e_tgt);
        check("probe_taken", {31'd0, isBranchTakenPredicted}, {31'd0, e_tk});
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
        step(1'b0, 32'd0, 1'b1, pc, tgt, taken);
    endtask

    task automatic do_reset();
        step(1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; lookupPc = '0; updateEn = 1'b0;
        updatePc = '0; updateTarget = '0; updateTaken = 1'b0;
        model_reset();
        do_reset();
        for (int pc = 0; pc <= 'hFC; pc += 4) probe(pc, 1'b0, 32'd0, 1'b0);

        upd(32'h100, 32'h200, 1'b1);
        probe(32'h100, 1'b1, 32'h200, 1'b1);
        probe(32'h102, 1'b1, 32'h200, 1'b1);
        upd(32'h100, 32'h200, 1'b1);
        upd(32'h100, 32'h200, 1'b1);
        upd(32'h100, 32'h200, 1'b0);
        probe(32'h100, 1'b1, 32'h200, 1'b1);
        upd(32'h100, 32'h200, 1'b0);
        probe(32'h100, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 32'h200, 1'b0);
        upd(32'h100, 32'h200, 1'b0);
        probe(32'h100, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 32'h240, 1'b1);
        probe(32'h100, 1'b1, 32'h240, 1'b0);

        do_reset();
        upd(32'h300, 32'h500, 1'b0);
        probe(32'h300, 1'b0, 32'h0, 1'b0);

        upd(32'h100, 32'h200, 1'b1);
        upd(32'h200, 32'h400, 1'b1);
        probe(32'h100, 1'b0, 32'h0, 1'b0);
        probe(32'h200, 1'b1, 32'h400, 1'b1);
        upd(32'h200, 32'h400, 1'b0);
        probe(32'h200, 1'b1, 32'h400, 1'b0);

        do_reset();
        step(1'b0, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1);
        check("same_cycle_miss", {31'd0, last_hit}, 32'd0);
        probe(32'h100, 1'b1, 32'h200, 1'b1);

        upd(32'h104, 32'h800, 1'b1);
        step(1'b1, 32'h100, 1'b1, 32'h104, 32'h900, 1'b1);
        probe(32'h100, 1'b0, 32'h0, 1'b0);
        probe(32'h104, 1'b0, 32'h0, 1'b0);

        for (int n = 0; n < 800; n++) begin
            logic [31:0] lk, pc, tgt;
            bit r;
            lk  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            tgt = $urandom;
            r   = ($urandom_range(0, 99) == 0);
            step(r, lk, $urandom_range(0, 2) != 0, pc, tgt, $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters. It sits beside next-PC generation in the fetch unit. Each cycle it looks up the current fetch PC combinationally and supplies `btbHit`, `btbPredictedPc` and `isBranchTakenPredicted` to the next-PC selector. It is trained one cycle later by resolved-branch updates from the execute stage.

## Interface
- `ENTRY_NUM`, default 64: number of entries. Must be a power of two, ≥ 2.
- `ADDR_WIDTH`, default 32: PC width; matches the `PC` type.
- `INDEX_WIDTH`, default log2(`ENTRY_NUM`): derived; not overridden.
- `clk` in 1: the only clock. One clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `lookupPc` in `ADDR_WIDTH`: current fetch PC.
- `btbHit` out 1: the entry is valid and its tag matches `lookupPc`.
- `btbPredictedPc` out `ADDR_WIDTH`: stored target of the hit entry.
- `isBranchTakenPredicted` out 1: counter MSB of the hit entry.
- `updateEn` in 1: a resolved branch is presented this cycle.
- `updatePc` in `ADDR_WIDTH`: PC of the resolved branch.
- `updateTarget` in `ADDR_WIDTH`: resolved target address.
- `updateTaken` in 1: the branch was actually taken.

## Operation
- Address split, for both lookup and update:
  - bits [1:0] ignored;
  - index = PC[INDEX_WIDTH+1:2];
  - tag = PC[ADDR_WIDTH-1:INDEX_WIDTH+2].
- Per-entry state:
  - valid (1 bit);
  - tag;
  - target (`ADDR_WIDTH`);
  - counter (2 bits): 0 = strongly not-taken, 1 = weakly not-taken, 2 = weakly taken, 3 = strongly taken.
- Lookup is purely combinational from `lookupPc` and the current state.
  - On a hit: `btbHit`=1, `btbPredictedPc`=target, `isBranchTakenPredicted`=counter[1].
  - On a miss: all three outputs are 0.
- Update, when `updateEn`=1 and `rst`=0, at the clock edge:
  - Hit (valid and tag equal), taken: counter = min(counter+1, 3); target = `updateTarget`.
  - Hit, not taken: counter = max(counter-1, 0); target unchanged; entry stays valid.
  - Miss, taken: allocate and overwrite any occupant. valid=1, tag and target written, counter=2.
  - Miss, not taken: no state change; never allocate.
- At most one update per cycle; there is no back-pressure.

## Timing
- Lookup latency is 0 cycles (same cycle as `lookupPc`).
- Update latency is 1 cycle: state written at the edge where `updateEn`=1 is visible to lookup from the next cycle.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents. No bypass.
- Reset (`rst`=1 at an edge):
  - every valid bit cleared;
  - every counter set to 1;
  - every target set to 0.
  - While `rst`=1, updates are ignored. From the first cycle after reset, all lookups miss and all outputs are 0.
- Reset asserted mid-training discards all learned state. An `updateEn` in the same cycle as `rst` has no effect.
- Counter arithmetic saturates at 0 and 3 and never wraps.
- Aliasing: two PCs with the same index and different tags evict each other only on taken updates. Aliased PCs with the same tag (impossible with full tags) are not a case.

## Test plan
- Reset, then sweep `lookupPc` over 0x0000_0000..0x0000_00FC:
  - required: `btbHit`=0, `btbPredictedPc`=0 and `isBranchTakenPredicted`=0 throughout.
- Update pc 0x100, target 0x200, taken; next cycle look up 0x100:
  - required: hit=1, target=0x200, predicted taken=1;
  - look up 0x102: same result (low bits ignored).
- Train pc 0x100 with taken ×3, then not-taken ×1:
  - required: predicted taken=1;
  - after a second not-taken: taken=0 with hit still 1;
  - after two more not-taken: counter stays at 0, hit=1.
- Update pc 0x300, not taken, on an empty BTB:
  - required: lookup of 0x300 misses.
- With 64 entries, allocate 0x100 (target 0x200), then update 0x200 taken, target 0x400 (same index, different tag):
  - required: 0x100 misses, 0x200 hits with target 0x400, counter=2.
- Same-cycle lookup and update of 0x100 on an empty BTB:
  - required: the lookup misses that cycle and hits the next cycle.
- Assert `rst` with `updateEn`=1 on trained entries:
  - required: all lookups miss afterwards.
